// File: rtl/zeroriscy_bnn_engine.sv
// BNN coprocessor: NCORE XNOR-popcount neuron lanes with max-pool/normalise and a writable parameter RAM.
// Define BNN_SAT_EN to clamp ACC/NORM/NORM8 results instead of wrapping modulo 2^ACC_W.
`timescale 1ns/1ps
module zeroriscy_bnn_engine #(
    parameter int NCORE  = 32,
    parameter int ACC_W  = 16,
    parameter int PDEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bnn_en_i,
    input  logic [2:0]  bnn_operator_i,
    input  logic [31:0] bnn_addr_i,
    input  logic [31:0] bnn_data_i,
    output logic [31:0] bnn_result_o,
    output logic        bnn_valid_o,
    output logic        bnn_ready_o
);
    localparam int PADDR_W = $clog2(PDEPTH);
    localparam int WSEL_W  = $clog2(NCORE);
    localparam int NGRP    = NCORE / 32;
    localparam int GRP_W   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int EW      = ACC_W + 4;
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_INI   = 3'd0,
        OP_ACC   = 3'd1,
        OP_POOL  = 3'd2,
        OP_NORM  = 3'd3,
        OP_ACTIV = 3'd4,
        OP_PWR   = 3'd5,
        OP_SETEN = 3'd6,
        OP_NORM8 = 3'd7
    } op_e;

    // Wide enough for the exact pool*8 - P value before clamping or wrapping.
    function automatic logic [ACC_W-1:0] clamp(input logic [EW-1:0] v);
`ifdef BNN_SAT_EN
        if ($signed(v) > $signed({4'b0000, 1'b0, {(ACC_W-1){1'b1}}}))
            return {1'b0, {(ACC_W-1){1'b1}}};
        else if ($signed(v) < $signed({4'b1111, 1'b1, {(ACC_W-1){1'b0}}}))
            return ACC_MIN;
        else
            return ACC_W'(v);
`else
        return ACC_W'(v);
`endif
    endfunction

    op_e                 w_op;
    logic                w_accept;
    logic [PADDR_W-1:0]  w_row;
    logic [WSEL_W-1:0]   w_sel;
    logic                w_unused;

    logic [NCORE*32-1:0] r_ram [PDEPTH];
    logic [NCORE*32-1:0] r_s0_row;

    logic                r_s0_vld;
    op_e                 r_s0_op;
    logic [31:0]         r_s0_data;
    logic [WSEL_W-2:0]   r_s0_sel;

    logic                r_s1_vld;
    op_e                 r_s1_op;
    logic [31:0]         r_s1_data;
    logic [WSEL_W-2:0]   r_s1_sel;
    logic [WSEL_W-1:0]   w_seten_lo;
    logic [WSEL_W-1:0]   w_seten_hi;

    logic [NCORE-1:0]    w_sign;
    logic [31:0]         w_act;
    logic [31:0]         r_result;
    logic                r_valid;
    logic                r_ready;

    assign w_op       = op_e'(bnn_operator_i);
    assign w_accept   = bnn_en_i && r_ready;
    assign w_row      = bnn_addr_i[PADDR_W-1:0];
    assign w_sel      = bnn_addr_i[WSEL_W+15:16];
    assign w_unused   = ^{bnn_addr_i[31:WSEL_W+16], bnn_addr_i[15:PADDR_W]};
    assign w_seten_lo = {r_s1_sel, 1'b0};
    assign w_seten_hi = {r_s1_sel, 1'b1};

    // Row read is registered at the accept edge, so a PWR one edge earlier is already visible.
    always_ff @(posedge clk) begin
        if (w_accept && w_op == OP_PWR)
            r_ram[w_row][{w_sel, 5'd0} +: 32] <= bnn_data_i;
        if (w_accept)
            r_s0_row <= r_ram[w_row];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_vld  <= 1'b0;
            r_s0_op   <= OP_INI;
            r_s0_data <= '0;
            r_s0_sel  <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_op   <= OP_INI;
            r_s1_data <= '0;
            r_s1_sel  <= '0;
        end else begin
            r_s0_vld  <= w_accept && (w_op != OP_PWR);
            r_s0_op   <= w_op;
            r_s0_data <= bnn_data_i;
            r_s0_sel  <= bnn_addr_i[WSEL_W+14:16];
            r_s1_vld  <= r_s0_vld;
            r_s1_op   <= r_s0_op;
            r_s1_data <= r_s0_data;
            r_s1_sel  <= r_s0_sel;
        end
    end

    for (genvar g = 0; g < NCORE; g++) begin : g_lane
        logic [31:0]      w_param;
        logic [ACC_W-1:0] w_opnd;
        logic [ACC_W-1:0] w_acc_nx;
        logic [ACC_W-1:0] w_pool_nx;
        logic [ACC_W-1:0] r_opnd;
        logic [ACC_W-1:0] r_acc;
        logic [ACC_W-1:0] r_pool;

        assign w_param   = r_s0_row[(NCORE-1-g)*32 +: 32];
        assign w_sign[g] = r_pool[ACC_W-1];

        always_comb begin
            w_opnd = '0;
            if (r_s0_op == OP_ACC)
                w_opnd = ACC_W'(2 * $countones(~(r_s0_data ^ w_param)));
            else if (r_s0_op == OP_NORM || r_s0_op == OP_NORM8)
                w_opnd = w_param[ACC_W-1:0];
        end

        always_comb begin
            w_acc_nx  = r_acc;
            w_pool_nx = r_pool;
            case (r_s1_op)
                OP_INI: begin
                    w_acc_nx  = r_s1_data[ACC_W-1:0];
                    w_pool_nx = ACC_MIN;
                end
                OP_ACC:   w_acc_nx = clamp(EW'($signed(r_acc)) + EW'(r_opnd));
                OP_POOL: begin
                    if ($signed(r_acc) > $signed(r_pool))
                        w_pool_nx = r_acc;
                    w_acc_nx = r_s1_data[ACC_W-1:0];
                end
                OP_NORM:  w_pool_nx = clamp((EW'($signed(r_pool)) <<< 3) - EW'($signed(r_opnd)));
                OP_NORM8: w_pool_nx = clamp(EW'($signed(r_pool)) - EW'($signed(r_opnd)));
                OP_SETEN: begin
                    if (w_seten_lo == WSEL_W'(g))
                        w_acc_nx = ACC_W'($signed(r_s1_data[31:16]));
                    else if (w_seten_hi == WSEL_W'(g))
                        w_acc_nx = ACC_W'($signed(r_s1_data[15:0]));
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_opnd <= '0;
                r_acc  <= '0;
                r_pool <= ACC_MIN;
            end else begin
                r_opnd <= w_opnd;
                if (r_s1_vld) begin
                    r_acc  <= w_acc_nx;
                    r_pool <= w_pool_nx;
                end
            end
        end
    end

    if (NGRP > 1) begin : g_grp
        logic [GRP_W-1:0] w_grp;
        assign w_grp = r_s1_sel[GRP_W-1:0];
        assign w_act = w_sign[{w_grp, 5'd0} +: 32];
    end else begin : g_nogrp
        assign w_act = w_sign[31:0];
    end

    // Ready drops while an ACTIV sits in S0 or S1 so the next command lands after its read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b1;
        end else begin
            r_valid <= r_s1_vld && (r_s1_op == OP_ACTIV);
            if (r_s1_vld && r_s1_op == OP_ACTIV)
                r_result <= w_act;
            r_ready <= !((w_accept && w_op == OP_ACTIV) || (r_s0_vld && r_s0_op == OP_ACTIV));
        end
    end

    assign bnn_result_o = r_result;
    assign bnn_valid_o  = r_valid;
    assign bnn_ready_o  = r_ready;

endmodule

// File: tb/tb_zeroriscy_bnn_engine.sv
// Directed bench: a 32-lane instance for most scenarios and a 64-lane instance for ACTIV group select.
`timescale 1ns/1ps
module tb_zeroriscy_bnn_engine;
    localparam logic [2:0] INI = 3'd0, ACC = 3'd1, POOL = 3'd2, NORM = 3'd3,
                           ACTIV = 3'd4, PWR = 3'd5, SETEN = 3'd6, NORM8 = 3'd7;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_a  = 1'b0;
    logic        en_b  = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] addr  = 32'd0;
    logic [31:0] data  = 32'd0;
    logic [31:0] res_a, res_b;
    logic        vld_a, vld_b, rdy_a, rdy_b;

    int n_assert = 0;
    int n_fail   = 0;
    int n_pulse  = 0;
    bit tgt_b    = 1'b0;
    logic [31:0] exp_sat_acc, exp_sat_norm, exp_sat_norm8;

    always #5 clk = ~clk;

    zeroriscy_bnn_engine #(.NCORE(32), .ACC_W(16), .PDEPTH(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bnn_en_i(en_a), .bnn_operator_i(op),
        .bnn_addr_i(addr), .bnn_data_i(data), .bnn_result_o(res_a),
        .bnn_valid_o(vld_a), .bnn_ready_o(rdy_a)
    );

    zeroriscy_bnn_engine #(.NCORE(64), .ACC_W(16), .PDEPTH(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bnn_en_i(en_b), .bnn_operator_i(op),
        .bnn_addr_i(addr), .bnn_data_i(data), .bnn_result_o(res_b),
        .bnn_valid_o(vld_b), .bnn_ready_o(rdy_b)
    );

    function automatic logic cur_rdy();
        return tgt_b ? rdy_b : rdy_a;
    endfunction

    function automatic logic cur_vld();
        return tgt_b ? vld_b : vld_a;
    endfunction

    function automatic logic [31:0] cur_res();
        return tgt_b ? res_b : res_a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one command at a negedge and returns right after the edge that accepts it.
    task automatic cmd(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
        int t;
        t = 0;
        @(negedge clk);
        op   = o;
        addr = a;
        data = d;
        en_a = !tgt_b;
        en_b = tgt_b;
        while (!cur_rdy() && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            n_assert++;
            n_fail++;
            $error("FAIL ready_timeout: observed ready=0 for %0d cycles expected ready=1", t);
        end
        @(posedge clk);
    endtask

    task automatic activ(input logic [31:0] a, input logic [31:0] exp, input string tag);
        cmd(ACTIV, a, 32'd0);
        @(negedge clk);
        en_a = 1'b0;
        en_b = 1'b0;
        check({tag, "_rdy_k"}, 32'(cur_rdy()), 32'd0);
        check({tag, "_vld_k"}, 32'(cur_vld()), 32'd0);
        @(negedge clk);
        check({tag, "_rdy_k1"}, 32'(cur_rdy()), 32'd0);
        @(negedge clk);
        check({tag, "_vld_k2"}, 32'(cur_vld()), 32'd1);
        check({tag, "_res"}, cur_res(), exp);
        check({tag, "_rdy_k2"}, 32'(cur_rdy()), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef BNN_SAT_EN
        exp_sat_acc   = 32'h0000_0000;
        exp_sat_norm  = 32'h0000_0000;
        exp_sat_norm8 = 32'hFFFF_FFFF;
`else
        exp_sat_acc   = 32'h0000_0003;
        exp_sat_norm  = 32'hFFFF_FFFF;
        exp_sat_norm8 = 32'hFFFF_FFFC;
`endif
        @(negedge clk);
        check("rst_ready", 32'(rdy_a), 32'd1);
        check("rst_valid", 32'(vld_a), 32'd0);
        check("rst_result", res_a, 32'd0);
        rst_n = 1'b1;
        activ(32'd0, 32'hFFFF_FFFF, "rst_activ");

        for (int w = 0; w < 32; w++) cmd(PWR, (32'(w) << 16) | 32'd3, 32'hFFFF_FFFF);
        for (int w = 0; w < 32; w++) cmd(PWR, (32'(w) << 16) | 32'd4, 32'h0000_0300);
        for (int w = 0; w < 32; w++) cmd(PWR, (32'(w) << 16) | 32'd2, 32'hFFFF_FFFF);

        cmd(INI, 32'd0, 32'd0);
        cmd(ACC, 32'd3, 32'hFFFF_FFFF);
        cmd(POOL, 32'd0, 32'd0);
        activ(32'd0, 32'h0000_0000, "acc_pool");
        cmd(NORM, 32'd3, 32'd0);
        activ(32'd0, 32'h0000_0000, "norm");
        cmd(NORM8, 32'd4, 32'd0);
        activ(32'd0, 32'hFFFF_FFFF, "norm8");

        cmd(INI, 32'd0, 32'h0000_FF9C);
        cmd(ACC, 32'd3, 32'hFFFF_FFFF);
        cmd(POOL, 32'd0, 32'd0);
        activ(32'd0, 32'hFFFF_FFFF, "chain1");
        cmd(INI, 32'd0, 32'h0000_FF9C);
        cmd(ACC, 32'd3, 32'hFFFF_FFFF);
        cmd(ACC, 32'd3, 32'hFFFF_FFFF);
        cmd(POOL, 32'd0, 32'd0);
        activ(32'd0, 32'h0000_0000, "chain2");

        cmd(INI, 32'd0, 32'h0000_FFE0);
        cmd(PWR, (32'd31 << 16) | 32'd2, 32'h0000_0000);
        cmd(ACC, 32'd2, 32'h0000_0000);
        cmd(POOL, 32'd0, 32'd0);
        activ(32'd0, 32'hFFFF_FFFE, "wr_rd");

        cmd(INI, 32'd0, 32'd0);
        cmd(SETEN, 32'd0, 32'h7FF0_7FF0);
        cmd(ACC, 32'd3, 32'hFFFF_FFFF);
        cmd(POOL, 32'd0, 32'd0);
        activ(32'd0, exp_sat_acc, "sat_acc");

        cmd(INI, 32'd0, 32'd0);
        cmd(SETEN, 32'd0, 32'h8010_8010);
        cmd(POOL, 32'd0, 32'd0);
        cmd(NORM8, 32'd4, 32'd0);
        activ(32'd0, exp_sat_norm8, "sat_norm8");

        cmd(INI, 32'd0, 32'h0000_1400);
        cmd(POOL, 32'd0, 32'd0);
        cmd(NORM, 32'd3, 32'd0);
        activ(32'd0, exp_sat_norm, "sat_norm");

        cmd(ACTIV, 32'd0, 32'd0);
        @(negedge clk);
        op   = INI;
        data = 32'h0000_FFFB;
        en_a = 1'b1;
        check("hs_rdy_k", 32'(rdy_a), 32'd0);
        @(negedge clk);
        check("hs_rdy_k1", 32'(rdy_a), 32'd0);
        check("hs_vld_k1", 32'(vld_a), 32'd0);
        @(negedge clk);
        check("hs_vld_k2", 32'(vld_a), 32'd1);
        check("hs_rdy_k2", 32'(rdy_a), 32'd1);
        check("hs_res", res_a, exp_sat_norm);
        @(posedge clk);
        @(negedge clk);
        en_a = 1'b0;
        check("hs_vld_k3", 32'(vld_a), 32'd0);
        cmd(POOL, 32'd0, 32'd0);
        activ(32'd0, 32'hFFFF_FFFF, "hs_ini");

        cmd(ACTIV, 32'd0, 32'd0);
        @(negedge clk);
        en_a = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_result", res_a, 32'd0);
        check("rstmid_ready", 32'(rdy_a), 32'd1);
        rst_n = 1'b1;
        n_pulse = 0;
        repeat (4) begin
            @(negedge clk);
            if (vld_a) n_pulse++;
        end
        check("rstmid_no_valid", 32'(n_pulse), 32'd0);
        activ(32'd0, 32'hFFFF_FFFF, "rstmid_state");

        tgt_b = 1'b1;
        cmd(INI, 32'd0, 32'd0);
        for (int s = 16; s < 32; s++) cmd(SETEN, 32'(s) << 16, 32'hFFFF_FFFF);
        cmd(POOL, 32'd0, 32'd0);
        activ(32'h0001_0000, 32'hFFFF_FFFF, "grp1");
        activ(32'h0000_0000, 32'h0000_0000, "grp0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
